// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcs_pkg
// Description : Shared types and constants for the 1000BASE-X PCS receive
//               synchronization block.
//               - pcs_state_t : synchronization FSM states
//               - comma patterns on code-group bits [9:3] (a..h order)
//               - default GOOD_CGS_MAX
//               - count_ones  : population count helper for a 10-bit vector
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_pkg;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC     = 4'd0,
        COMMA_DETECT_1   = 4'd1,
        ACQUIRE_SYNC_1   = 4'd2,
        COMMA_DETECT_2   = 4'd3,
        ACQUIRE_SYNC_2   = 4'd4,
        COMMA_DETECT_3   = 4'd5,
        SYNC_ACQUIRED_1  = 4'd6,
        SYNC_ACQUIRED_2  = 4'd7,
        SYNC_ACQUIRED_2A = 4'd8,
        SYNC_ACQUIRED_3  = 4'd9,
        SYNC_ACQUIRED_3A = 4'd10,
        SYNC_ACQUIRED_4  = 4'd11,
        SYNC_ACQUIRED_4A = 4'd12
    } pcs_state_t;

    // Seven-bit comma sequences, both disparities (bits abcdeif).
    localparam logic [6:0] c_comma_plus  = 7'b0011111;
    localparam logic [6:0] c_comma_minus = 7'b1100000;

    localparam int GOOD_CGS_MAX_DEFAULT = 3;

    function automatic logic [3:0] count_ones(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_cg_classify.sv
`default_nettype none
// ============================================================================
// Module      : pcs_cg_classify
// Description : Combinational code-group checker. Flags commas, checks the
//               ones-count validity of a 10-bit code-group (running disparity
//               is deliberately not tracked) and derives cgbad, which also
//               treats a comma at an odd position as bad.
// Ports       : i_pudi    [9:0] code-group, bit9 = a ... bit0 = j
//               i_rx_even       even/odd tag held before this group
//               o_comma         group carries a comma
//               o_valid         group passes the ones-count checks
//               o_cgbad         group is invalid or a misaligned comma
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_cg_classify
    import pcs_pkg::*;
(
    input  logic [9:0] i_pudi,
    input  logic       i_rx_even,
    output logic       o_comma,
    output logic       o_valid,
    output logic       o_cgbad
);

    logic [3:0] w_ones_hi;
    logic [3:0] w_ones_lo;
    logic [3:0] w_ones_all;

    assign w_ones_hi  = count_ones({4'b0000, i_pudi[9:4]});
    assign w_ones_lo  = count_ones({6'b000000, i_pudi[3:0]});
    assign w_ones_all = count_ones(i_pudi);

    assign o_comma = (i_pudi[9:3] == c_comma_plus) || (i_pudi[9:3] == c_comma_minus);

    // 6b sub-block, 4b sub-block and whole group must each stay near balance.
    assign o_valid = (w_ones_hi  >= 4'd2) && (w_ones_hi  <= 4'd4) &&
                     (w_ones_lo  >= 4'd1) && (w_ones_lo  <= 4'd3) &&
                     (w_ones_all >= 4'd4) && (w_ones_all <= 4'd6);

    assign o_cgbad = !o_valid || (o_comma && i_rx_even);

endmodule
`default_nettype wire

// File: rtl/pcs_sync.sv
`default_nettype none
// ============================================================================
// Module      : pcs_sync
// Description : 1000BASE-X PCS receive synchronization state machine.
//               Acquires code-group alignment from commas, tolerates sparse
//               errors while synchronized and forwards each code-group with
//               its even/odd tag.
// Ports       : Clk              system clock, rising edge
//               mr_main_reset    asynchronous active-low reset
//               power_on         synchronous force to LOSS_OF_SYNC
//               PUDI      [9:0]  received code-group
//               PUDI_indicate    PUDI qualifier; FSM advances only when high
//               code_sync_status 1 = synchronized (registered)
//               SUDI     [10:0]  {rx_even, code-group} (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_sync
    import pcs_pkg::*;
#(
    parameter int GOOD_CGS_MAX = GOOD_CGS_MAX_DEFAULT
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        power_on,
    input  logic [9:0]  PUDI,
    input  logic        PUDI_indicate,
    output logic        code_sync_status,
    output logic [10:0] SUDI
);

    // good_cgs is only 2 bits, so the threshold is clamped to keep it from
    // wrapping if a larger value is configured.
    localparam logic [1:0] c_gc_max = (GOOD_CGS_MAX > 3) ? 2'd3 : GOOD_CGS_MAX[1:0];

    pcs_state_t  r_state;
    pcs_state_t  w_state_next;
    logic        r_rx_even;
    logic        w_rx_even_next;
    logic [1:0]  r_good_cgs;
    logic [1:0]  w_good_cgs_next;
    logic        r_sync;
    logic        w_sync_next;
    logic [10:0] r_sudi;

    logic w_comma;
    logic w_valid;
    logic w_cgbad;
    logic w_cggood;
    logic w_data;
    logic w_gc_full;

    pcs_cg_classify u_classify (
        .i_pudi    (PUDI),
        .i_rx_even (r_rx_even),
        .o_comma   (w_comma),
        .o_valid   (w_valid),
        .o_cgbad   (w_cgbad)
    );

    assign w_cggood  = !w_cgbad;
    assign w_data    = w_valid && !w_comma;
    assign w_gc_full = (r_good_cgs >= c_gc_max);

    always_comb begin
        w_state_next    = r_state;
        w_good_cgs_next = r_good_cgs;

        case (r_state)
            LOSS_OF_SYNC: begin
                if (w_comma) w_state_next = COMMA_DETECT_1;
            end
            COMMA_DETECT_1: w_state_next = w_data ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2: w_state_next = w_data ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3: w_state_next = w_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (w_cgbad)                     w_state_next = LOSS_OF_SYNC;
                else if (w_comma && !r_rx_even)  w_state_next = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (w_cgbad)                     w_state_next = LOSS_OF_SYNC;
                else if (w_comma && !r_rx_even)  w_state_next = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: begin
                if (w_cgbad) begin
                    w_state_next    = SYNC_ACQUIRED_2;
                    w_good_cgs_next = 2'd0;
                end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (w_cggood) begin
                    w_good_cgs_next = 2'd1;
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_next = SYNC_ACQUIRED_2A;
                        SYNC_ACQUIRED_3: w_state_next = SYNC_ACQUIRED_3A;
                        default:         w_state_next = SYNC_ACQUIRED_4A;
                    endcase
                end else begin
                    w_good_cgs_next = 2'd0;
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_next = SYNC_ACQUIRED_3;
                        SYNC_ACQUIRED_3: w_state_next = SYNC_ACQUIRED_4;
                        default:         w_state_next = LOSS_OF_SYNC;
                    endcase
                end
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                if (w_cggood && !w_gc_full) begin
                    w_good_cgs_next = r_good_cgs + 2'd1;
                end else if (w_cggood) begin
                    // Enough consecutive good groups: recover one level.
                    w_good_cgs_next = 2'd0;
                    case (r_state)
                        SYNC_ACQUIRED_2A: w_state_next = SYNC_ACQUIRED_1;
                        SYNC_ACQUIRED_3A: w_state_next = SYNC_ACQUIRED_2;
                        default:          w_state_next = SYNC_ACQUIRED_3;
                    endcase
                end else begin
                    w_good_cgs_next = 2'd0;
                    case (r_state)
                        SYNC_ACQUIRED_2A: w_state_next = SYNC_ACQUIRED_3;
                        SYNC_ACQUIRED_3A: w_state_next = SYNC_ACQUIRED_4;
                        default:          w_state_next = LOSS_OF_SYNC;
                    endcase
                end
            end
            default: begin
                w_state_next    = LOSS_OF_SYNC;
                w_good_cgs_next = 2'd0;
            end
        endcase

        // COMMA_DETECT_n is never a self-loop, so landing in one always means
        // entering it: realign the even/odd tag there, toggle otherwise.
        w_rx_even_next = ((w_state_next == COMMA_DETECT_1) ||
                          (w_state_next == COMMA_DETECT_2) ||
                          (w_state_next == COMMA_DETECT_3)) ? 1'b1 : !r_rx_even;

        w_sync_next = (w_state_next == SYNC_ACQUIRED_1)  ||
                      (w_state_next == SYNC_ACQUIRED_2)  ||
                      (w_state_next == SYNC_ACQUIRED_2A) ||
                      (w_state_next == SYNC_ACQUIRED_3)  ||
                      (w_state_next == SYNC_ACQUIRED_3A) ||
                      (w_state_next == SYNC_ACQUIRED_4)  ||
                      (w_state_next == SYNC_ACQUIRED_4A);
    end

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state    <= LOSS_OF_SYNC;
            r_rx_even  <= 1'b0;
            r_good_cgs <= 2'd0;
            r_sync     <= 1'b0;
            r_sudi     <= 11'd0;
        end else if (power_on) begin
            r_state    <= LOSS_OF_SYNC;
            r_rx_even  <= 1'b0;
            r_good_cgs <= 2'd0;
            r_sync     <= 1'b0;
            r_sudi     <= 11'd0;
        end else if (PUDI_indicate) begin
            r_state    <= w_state_next;
            r_rx_even  <= w_rx_even_next;
            r_good_cgs <= w_good_cgs_next;
            r_sync     <= w_sync_next;
            r_sudi     <= {w_rx_even_next, PUDI};
        end
    end

    assign code_sync_status = r_sync;
    assign SUDI             = r_sudi;

endmodule
`default_nettype wire

// File: tb/tb_pcs_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_sync
// Description : Directed self-checking bench for pcs_sync. Drives code-group
//               sequences and compares SUDI, code_sync_status and the FSM
//               state against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_sync;
    import pcs_pkg::*;

    localparam logic [9:0] c_k = 10'b0011111010;  // K28.5-
    localparam logic [9:0] c_d = 10'b0110110101;  // D16.2
    localparam logic [9:0] c_z = 10'b0000000000;  // invalid

    logic        Clk = 1'b0;
    logic        mr_main_reset;
    logic        power_on;
    logic [9:0]  PUDI;
    logic        PUDI_indicate;
    logic        code_sync_status;
    logic [10:0] SUDI;

    int passed = 0;
    int total  = 0;

    pcs_sync dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .power_on         (power_on),
        .PUDI             (PUDI),
        .PUDI_indicate    (PUDI_indicate),
        .code_sync_status (code_sync_status),
        .SUDI             (SUDI)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input pcs_state_t exp);
        check(tag, {7'b0, dut.r_state}, {7'b0, exp});
    endtask

    task automatic step(input logic [9:0] cg, input logic ind,
                        input logic [10:0] exp_sudi, input logic exp_sync,
                        input string tag);
        PUDI          = cg;
        PUDI_indicate = ind;
        @(posedge Clk);
        #1;
        check({tag, "_sudi"}, SUDI, exp_sudi);
        check({tag, "_sync"}, {10'b0, code_sync_status}, {10'b0, exp_sync});
    endtask

    // From LOSS_OF_SYNC with rx_even=0: three K28.5/D16.2 pairs.
    task automatic acquire(input string tag);
        step(c_k, 1'b1, {1'b1, c_k}, 1'b0, {tag, "_k1"});
        step(c_d, 1'b1, {1'b0, c_d}, 1'b0, {tag, "_d1"});
        step(c_k, 1'b1, {1'b1, c_k}, 1'b0, {tag, "_k2"});
        step(c_d, 1'b1, {1'b0, c_d}, 1'b0, {tag, "_d2"});
        step(c_k, 1'b1, {1'b1, c_k}, 1'b0, {tag, "_k3"});
        step(c_d, 1'b1, {1'b0, c_d}, 1'b1, {tag, "_d3"});
        check_state({tag, "_state"}, SYNC_ACQUIRED_1);
    endtask

    initial begin
        mr_main_reset = 1'b0;
        power_on      = 1'b0;
        PUDI          = 10'h3ff;
        PUDI_indicate = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_sudi", SUDI, 11'd0);
        check("rst_sync", {10'b0, code_sync_status}, 11'd0);
        check_state("rst_state", LOSS_OF_SYNC);
        mr_main_reset = 1'b1;

        // Acquisition and steady alternating tag.
        acquire("acq");
        step(c_k, 1'b1, {1'b1, c_k}, 1'b1, "alt_k1");
        step(c_d, 1'b1, {1'b0, c_d}, 1'b1, "alt_d1");
        step(c_k, 1'b1, {1'b1, c_k}, 1'b1, "alt_k2");
        step(c_d, 1'b1, {1'b0, c_d}, 1'b1, "alt_d2");

        // One error, then GOOD_CGS_MAX+1 good groups climb back to level 1.
        step(c_z, 1'b1, {1'b1, c_z}, 1'b1, "tol_bad");
        check_state("tol_sa2", SYNC_ACQUIRED_2);
        step(c_d, 1'b1, {1'b0, c_d}, 1'b1, "tol_g1");
        step(c_d, 1'b1, {1'b1, c_d}, 1'b1, "tol_g2");
        step(c_d, 1'b1, {1'b0, c_d}, 1'b1, "tol_g3");
        check_state("tol_sa2a", SYNC_ACQUIRED_2A);
        step(c_d, 1'b1, {1'b1, c_d}, 1'b1, "tol_g4");
        check_state("tol_sa1", SYNC_ACQUIRED_1);

        // Unqualified cycles hold every register.
        for (int i = 0; i < 10; i++) begin
            step(10'($urandom), 1'b0, {1'b1, c_d}, 1'b1, "hold");
        end

        // Four errors each separated by one good group -> loss of sync.
        step(c_z, 1'b1, {1'b0, c_z}, 1'b1, "los_b1");
        step(c_d, 1'b1, {1'b1, c_d}, 1'b1, "los_g1");
        step(c_z, 1'b1, {1'b0, c_z}, 1'b1, "los_b2");
        step(c_d, 1'b1, {1'b1, c_d}, 1'b1, "los_g2");
        step(c_z, 1'b1, {1'b0, c_z}, 1'b1, "los_b3");
        step(c_d, 1'b1, {1'b1, c_d}, 1'b1, "los_g3");
        check_state("los_sa4a", SYNC_ACQUIRED_4A);
        step(c_z, 1'b1, {1'b0, c_z}, 1'b0, "los_b4");
        check_state("los_state", LOSS_OF_SYNC);

        // power_on overrides a qualified group while synchronized.
        acquire("acq2");
        power_on = 1'b1;
        step(c_d, 1'b1, 11'd0, 1'b0, "pwr");
        check_state("pwr_state", LOSS_OF_SYNC);
        power_on = 1'b0;

        // Comma at an odd position while in ACQUIRE_SYNC_1.
        step(c_k, 1'b1, {1'b1, c_k}, 1'b0, "odd_k1");
        step(c_d, 1'b1, {1'b0, c_d}, 1'b0, "odd_d1");
        step(c_d, 1'b1, {1'b1, c_d}, 1'b0, "odd_d2");
        check_state("odd_as1", ACQUIRE_SYNC_1);
        step(c_k, 1'b1, {1'b0, c_k}, 1'b0, "odd_k2");
        check_state("odd_state", LOSS_OF_SYNC);

        // Asynchronous reset between clock edges while synchronized.
        acquire("acq3");
        #2;
        mr_main_reset = 1'b0;
        #1;
        check("arst_sudi", SUDI, 11'd0);
        check("arst_sync", {10'b0, code_sync_status}, 11'd0);
        #1;
        mr_main_reset = 1'b1;
        check_state("arst_state", LOSS_OF_SYNC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
